// File: rtl/mrelbp_pkg.sv
// -----------------------------------------------------------------------------
// mrelbp_pkg
//   Shared definitions for the MRELBP pixel streamer: datapath widths, frame
//   side lengths, FSM state encoding and the frame-length helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package mrelbp_pkg;

  localparam int IN_W   = 32;   // packed input word, four pixels
  localparam int PIX_W  = 8;    // one pixel
  localparam int SIZE_S = 128;  // frame side with size select = 0
  localparam int SIZE_L = 256;  // frame side with size select = 1
  localparam int CNT_W  = 17;   // holds 256*256 = 65536
  localparam int WCNT_W = 15;   // holds 65536/4 = 16384

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Number of pixels in one frame for the given size select.
  function automatic logic [CNT_W-1:0] frame_pixels(input logic size_sel);
    logic [CNT_W-1:0] n;
    if (size_sel) begin
      n = CNT_W'(SIZE_L * SIZE_L);
    end else begin
      n = CNT_W'(SIZE_S * SIZE_S);
    end
    return n;
  endfunction

endpackage

// File: rtl/mrelbp_word_unpacker.sv
// -----------------------------------------------------------------------------
// mrelbp_word_unpacker
//   Single-word buffer that splits a 32-bit word into four pixels, byte 0 first.
//   Ports:
//     clk, rst_n, srst   clock, active-low reset, active-high soft reset (both sync)
//     word_en            upstream words may be accepted (streaming, words left)
//     word_data/valid    upstream word
//     word_ready         combinational ready towards upstream
//     word_take          a word is loaded this cycle
//     pix_data/valid     registered pixel towards MRELBP
//     pix_ready          MRELBP ready
// -----------------------------------------------------------------------------
module mrelbp_word_unpacker
  import mrelbp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              srst,
  input  logic              word_en,
  input  logic [IN_W-1:0]   word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              word_take,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready
);

  logic [IN_W-1:0] buf_r;
  logic            buf_valid_r;
  logic [1:0]      idx_r;

  logic pix_fire_s;
  logic drain_s;

  // Handshake decode; a word may load while the last byte of the previous one leaves.
  always_comb begin
    pix_fire_s = buf_valid_r & pix_ready;
    drain_s    = pix_fire_s & (idx_r == 2'd3);
    word_ready = word_en & (~buf_valid_r | drain_s);
    word_take  = word_ready & word_valid;
  end

  // Word buffer, valid flag and byte index.
  always_ff @(posedge clk) begin
    if (!rst_n || srst) begin
      buf_r       <= '0;
      buf_valid_r <= 1'b0;
      idx_r       <= 2'd0;
    end else if (word_take) begin
      buf_r       <= word_data;
      buf_valid_r <= 1'b1;
      idx_r       <= 2'd0;
    end else if (pix_fire_s) begin
      idx_r       <= idx_r + 2'd1;
      buf_valid_r <= (idx_r != 2'd3);
    end
  end

  assign pix_data  = buf_r[{idx_r, 3'b000} +: PIX_W];
  assign pix_valid = buf_valid_r;

endmodule

// File: rtl/mrelbp_pixel_streamer.sv
// -----------------------------------------------------------------------------
// mrelbp_pixel_streamer
//   Transmit side of the MRELBP pixel AXI-Stream: unpacks 32-bit words into
//   8-bit pixels and sends exactly side*side pixels per frame.
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset
//     control_reg_i     [0] start (level), [1] soft reset
//     config_reg_i      [0] frame size select (latched at frame start)
//     s_axis_*          packed word input (tdata/tvalid/tready)
//     m_axis_*          pixel output (tdata/tvalid/tready/tlast)
//     busy_o            frame in progress
//     irq_o             one-cycle frame-done pulse
// -----------------------------------------------------------------------------
module mrelbp_pixel_streamer
  import mrelbp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        control_reg_i,
  input  logic [0:0]        config_reg_i,
  input  logic [IN_W-1:0]   s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [PIX_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy_o,
  output logic              irq_o
);

  state_t              state_r;
  logic [CNT_W-1:0]    pix_left_r;
  logic [WCNT_W-1:0]   word_left_r;
  logic                irq_r;

  logic                srst_s;
  logic                start_s;
  logic                word_en_s;
  logic                word_take_s;
  logic                pix_fire_s;
  logic                last_fire_s;
  logic                m_valid_s;
  logic [CNT_W-1:0]    frame_len_s;
  logic [WCNT_W-1:0]   word_len_s;

  // Control decode and frame-length lookup.
  always_comb begin
    srst_s      = control_reg_i[1];
    start_s     = control_reg_i[0];
    // Once the last word of the frame is in, upstream is no longer served.
    word_en_s   = (state_r == ST_STREAM) & (word_left_r != '0);
    pix_fire_s  = m_valid_s & m_axis_tready;
    last_fire_s = pix_fire_s & (pix_left_r == 17'd1);
    frame_len_s = frame_pixels(config_reg_i[0]);
    word_len_s  = WCNT_W'(frame_len_s >> 2);
  end

  mrelbp_word_unpacker u_unpacker (
    .clk        (clk),
    .rst_n      (rst_n),
    .srst       (srst_s),
    .word_en    (word_en_s),
    .word_data  (s_axis_tdata),
    .word_valid (s_axis_tvalid),
    .word_ready (s_axis_tready),
    .word_take  (word_take_s),
    .pix_data   (m_axis_tdata),
    .pix_valid  (m_valid_s),
    .pix_ready  (m_axis_tready)
  );

  // Frame FSM with pixel/word counters and the frame-done interrupt.
  always_ff @(posedge clk) begin
    if (!rst_n || srst_s) begin
      state_r     <= ST_IDLE;
      pix_left_r  <= '0;
      word_left_r <= '0;
      irq_r       <= 1'b0;
    end else begin
      irq_r <= 1'b0;
      if (word_take_s) begin
        word_left_r <= word_left_r - 15'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r     <= ST_STREAM;
            pix_left_r  <= frame_len_s;
            word_left_r <= word_len_s;
          end
        end
        ST_STREAM: begin
          if (pix_fire_s) begin
            pix_left_r <= pix_left_r - 17'd1;
          end
          if (last_fire_s) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          irq_r   <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_axis_tvalid = m_valid_s;
  assign m_axis_tlast  = m_valid_s & (pix_left_r == 17'd1);
  assign busy_o        = (state_r == ST_STREAM);
  assign irq_o         = irq_r;

endmodule

// File: tb/tb_mrelbp_pixel_streamer.sv
// -----------------------------------------------------------------------------
// tb_mrelbp_pixel_streamer
//   Randomised scoreboard bench. Accepted input words are expanded into their
//   four expected pixels (byte 0 first, tlast on pixel side*side of the frame);
//   a monitor compares every presented pixel and the handshake/status outputs
//   against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_mrelbp_pixel_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  control_reg_i;
  logic [0:0]  config_reg_i;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy_o;
  logic        irq_o;

  always #5 clk = ~clk;

  mrelbp_pixel_streamer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .control_reg_i (control_reg_i),
    .config_reg_i  (config_reg_i),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy_o        (busy_o),
    .irq_o         (irq_o)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } pix_t;

  int compared   = 0;
  int mismatched = 0;

  // stimulus knobs
  int valid_pct     = 100;
  int ready_pct     = 100;
  bit fixed_pending = 1'b1;

  // reference model state
  pix_t exp_q[$];
  bit   active      = 1'b0;
  int   hold        = 0;
  int   n_pix       = 0;
  int   words_left  = 0;
  int   pushed      = 0;
  int   popped      = 0;
  int   frames_done = 0;
  bit [1:0] irq_pipe = 2'b00;
  bit   post_rst    = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // input driver: AXI-correct word source plus random output back-pressure
  initial begin : driver
    logic hs;
    int   gap;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 32'h0;
    m_axis_tready = 1'b0;
    gap = 0;
    hs  = 1'b0;
    forever begin
      @(negedge clk);
      if (!s_axis_tvalid || hs) begin
        if (fixed_pending) begin
          s_axis_tdata  = 32'h44332211;
          s_axis_tvalid = 1'b1;
          fixed_pending = 1'b0;
          gap = 3;
        end else if (gap > 0) begin
          s_axis_tvalid = 1'b0;
          gap--;
        end else if (int'($urandom_range(99)) < valid_pct) begin
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = $urandom;
        end else begin
          s_axis_tvalid = 1'b0;
        end
      end
      m_axis_tready = (int'($urandom_range(99)) < ready_pct);
      #1;
      hs = s_axis_tvalid && s_axis_tready && rst_n && !control_reg_i[1];
    end
  end

  // monitor / scoreboard
  initial begin : monitor
    pix_t e;
    logic rst_now, m_hs, fin, exp_ready;
    forever begin
      @(negedge clk);
      #1;
      rst_now = !rst_n || control_reg_i[1];
      m_hs    = m_axis_tvalid && m_axis_tready;
      chk("irq_o", 32'(irq_o), 32'(irq_pipe[1]));
      chk("busy_o", 32'(busy_o), 32'(active));
      chk("m_tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("m_tdata", 32'(m_axis_tdata), 32'(exp_q[0].d));
        chk("m_tlast", 32'(m_axis_tlast), 32'(exp_q[0].l));
      end
      if (post_rst) begin
        chk("m_tdata_reset", 32'(m_axis_tdata), 32'h0);
        chk("m_tlast_reset", 32'(m_axis_tlast), 32'h0);
      end
      post_rst = 1'b0;
      exp_ready = active && (words_left > 0) &&
                  (exp_q.size() == 0 || (exp_q.size() == 1 && m_hs));
      chk("s_tready", 32'(s_axis_tready), 32'(exp_ready));
      if (!rst_now) begin
        fin = 1'b0;
        if (m_hs) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL spurious_pixel: got %0h expected no pixel", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            popped++;
            if (e.l) begin
              fin = 1'b1;
              frames_done++;
            end
          end
        end
        if (s_axis_tvalid && s_axis_tready && active && words_left > 0) begin
          for (int k = 0; k < 4; k++) begin
            pushed++;
            e.d = s_axis_tdata[8*k +: 8];
            e.l = (pushed == n_pix);
            exp_q.push_back(e);
          end
          words_left--;
        end
        if (fin) begin
          active = 1'b0;
          hold   = 1;
        end else if (!active) begin
          if (hold > 0) begin
            hold--;
          end else if (control_reg_i[0]) begin
            active     = 1'b1;
            n_pix      = config_reg_i[0] ? 65536 : 16384;
            words_left = n_pix / 4;
            pushed     = 0;
            popped     = 0;
          end
        end
        irq_pipe = {irq_pipe[0], fin};
      end else begin
        exp_q.delete();
        active     = 1'b0;
        hold       = 0;
        words_left = 0;
        irq_pipe   = 2'b00;
        post_rst   = 1'b1;
      end
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (frames_done < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    compared++;
    if (frames_done < n) begin
      mismatched++;
      $display("FAIL frame_timeout: got %0d frames, expected %0d", frames_done, n);
    end
  endtask

  task automatic wait_pixels(input int n, input int budget);
    int c = 0;
    while (popped < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    compared++;
    if (popped < n) begin
      mismatched++;
      $display("FAIL pixel_timeout: got %0d pixels, expected %0d", popped, n);
    end
  endtask

  initial begin : main
    rst_n         = 1'b0;
    control_reg_i = 2'b00;
    config_reg_i  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1: side 128, full rate, start held so frame 2 follows directly.
    control_reg_i = 2'b01;
    wait_frames(1, 20000);

    // Frame 2: random gaps/stalls, start released, size select flipped mid-frame.
    valid_pct = 85;
    ready_pct = 85;
    repeat (50) @(negedge clk);
    control_reg_i = 2'b00;
    repeat (500) @(negedge clk);
    config_reg_i = 1'b1;
    wait_frames(2, 30000);
    repeat (10) @(negedge clk);

    // Frame 3: side 256; soft reset past the 128-frame length.
    valid_pct = 100;
    ready_pct = 100;
    control_reg_i = 2'b01;
    repeat (5) @(negedge clk);
    control_reg_i = 2'b00;
    wait_pixels(16500, 20000);
    control_reg_i = 2'b10;
    @(negedge clk);
    control_reg_i = 2'b00;
    config_reg_i  = 1'b0;
    repeat (5) @(negedge clk);

    // Frame 4: restart after soft reset, side 128, random traffic.
    valid_pct = 90;
    ready_pct = 90;
    control_reg_i = 2'b01;
    repeat (5) @(negedge clk);
    control_reg_i = 2'b00;
    wait_frames(3, 25000);
    repeat (30) @(negedge clk);
    chk("frames_total", 32'(frames_done), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
